// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and oversampling constants.
// Used by both receiver and transmitter.
package uart_pkg;

  // Oversampling ratio of s_tick relative to the bit rate.
  localparam int OVS     = 16;
  // Tick count at which the start bit is checked (middle of the bit).
  localparam int OVS_MID = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs (rx, CTS, ...).
// Reset value is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; only the asynchronous reset touches them.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta_q <= {WIDTH{RST_VAL}};
      sync_q <= {WIDTH{RST_VAL}};
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receive path: 16x oversampled, mid-bit start validation,
// LSB-first data, stop-bit check with a held frame error flag.
module receiver #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            rst,
  input  logic            rx_en,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            rx_busy,
  output logic            frame_err
);

  import uart_pkg::*;

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int KW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [3:0]    S_MID  = 4'(OVS_MID);
  localparam logic [3:0]    S_LAST = 4'(OVS - 1);
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [KW-1:0] K_LAST = KW'(STOP_BITS - 1);

  logic rx_s;

  rx_state_t       state_q,     state_d;
  logic [3:0]      s_q,         s_d;
  logic [NW-1:0]   n_q,         n_d;
  logic [KW-1:0]   k_q,         k_d;
  logic [DBIT-1:0] b_q,         b_d;
  logic            err_q,       err_d;
  logic [DBIT-1:0] dout_q,      dout_d;
  logic            frame_err_q, frame_err_d;
  logic            done_q,      done_d;

  // The soft clear deliberately leaves the synchronizer running.
  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_rx_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (rx),
    .q      (rx_s)
  );

  // Next-state logic: soft clear first, then one branch per FSM state.
  always_comb begin
    // NOTE: every _d signal gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    k_d         = k_q;
    b_d         = b_q;
    err_d       = err_q;
    dout_d      = dout_q;
    frame_err_d = frame_err_q;
    done_d      = 1'b0;

    if (rst) begin
      state_d     = IDLE;
      s_d         = '0;
      n_d         = '0;
      k_d         = '0;
      b_d         = '0;
      err_d       = 1'b0;
      dout_d      = '0;
      frame_err_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A falling edge is enough to leave IDLE; no tick needed.
          if (rx_en && !rx_s) begin
            state_d = START;
            s_d     = '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == S_MID) begin
              if (!rx_s) begin
                state_d = DATA;
                s_d     = '0;
                n_d     = '0;
                err_d   = 1'b0;
              end else begin
                // Line went back high before mid-bit: glitch, no frame.
                state_d = IDLE;
              end
            end else begin
              s_d = s_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == S_LAST) begin
              b_d = {rx_s, b_q[DBIT-1:1]};
              s_d = '0;
              if (n_q == N_LAST) begin
                state_d = STOP;
                k_d     = '0;
              end else begin
                n_d = n_q + NW'(1);
              end
            end else begin
              s_d = s_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == S_STOP) begin
              err_d = err_q | ~rx_s;
              s_d   = '0;
              if (k_q == K_LAST) begin
                // A bad stop bit still delivers the byte, just flagged.
                state_d     = IDLE;
                dout_d      = b_q;
                frame_err_d = err_q | ~rx_s;
                done_d      = 1'b1;
              end else begin
                k_d = k_q + KW'(1);
              end
            end else begin
              s_d = s_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      b_q         <= '0;
      err_q       <= 1'b0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      k_q         <= k_d;
      b_q         <= b_d;
      err_q       <= err_d;
      dout_q      <= dout_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
    end
  end

  assign dout         = dout_q;
  assign frame_err    = frame_err_q;
  assign rx_done_tick = done_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: a bench-side serial line driver plays
// the transmitter, expected bytes go into a scoreboard queue, and a
// monitor pops and compares on every rx_done_tick.
module tb_receiver;

  localparam int DBIT     = 8;
  localparam int TICK_DIV = 4;
  localparam int BIT_T    = 16;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic            clk    = 1'b0;
  logic            arst_n = 1'b0;
  logic            rst    = 1'b0;
  logic            rx_en  = 1'b0;
  logic            rx     = 1'b1;
  logic            s_tick = 1'b0;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            rx_busy;
  logic            frame_err;

  exp_t   exp_q[$];
  int     n_tests    = 0;
  int     n_fail     = 0;
  int     done_cnt   = 0;
  int     div_cnt    = 0;
  longint tick_cnt   = 0;
  longint last_stamp = 0;
  longint gap        = 0;
  bit     busy_seen  = 1'b0;

  receiver #(.DBIT(DBIT), .SB_TICK(16), .STOP_BITS(1)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .rst          (rst),
    .rx_en        (rx_en),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .rx_busy      (rx_busy),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Bench baud generator: one-clk s_tick every TICK_DIV clocks, set up on
  // the falling edge so it is stable at the sampling edge.
  always @(negedge clk) begin
    if (div_cnt == TICK_DIV - 1) begin
      div_cnt = 0;
      s_tick  = 1'b1;
    end else begin
      div_cnt = div_cnt + 1;
      s_tick  = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (s_tick && !rst) tick_cnt = tick_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (rx_busy) busy_seen = 1'b1;
    if (rx_done_tick) begin
      done_cnt   = done_cnt + 1;
      gap        = tick_cnt - last_stamp;
      last_stamp = tick_cnt;
      if (exp_q.size() == 0) begin
        n_tests = n_tests + 1;
        n_fail  = n_fail + 1;
        $display("FAIL unexpected_strobe: got dout=0x%0h, expected no strobe", dout);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e.data));
        check("frame_err", 32'(frame_err), 32'(e.ferr));
      end
    end
  end

  // Wait for n s_ticks; return just after the edge that consumed the last.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!s_tick);
    end
    if (n > 0) #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  // One 8N1 frame. A bad stop bit is low for the first 10 ticks only, so
  // it covers the receiver's mid-bit sample yet lets the line recover
  // before any restart triggered by it reaches its own start check.
  task automatic send_frame(input logic [7:0] d, input bit good_stop,
                            input bit expect_rx);
    exp_t e;
    if (expect_rx) begin
      e.data = d;
      e.ferr = ~good_stop;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    wait_ticks(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(BIT_T);
    end
    if (good_stop) begin
      rx = 1'b1;
      wait_ticks(BIT_T);
    end else begin
      rx = 1'b0;
      wait_ticks(10);
      rx = 1'b1;
      wait_ticks(BIT_T - 10);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [7:0] d;
    bit good;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_done", 32'(rx_done_tick), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    arst_n = 1'b1;
    rx_en  = 1'b1;
    idle(4);

    // Loopback bytes.
    send_frame(8'h55, 1'b1, 1'b1);
    idle(2);
    send_frame(8'hF1, 1'b1, 1'b1);
    idle(2);
    send_frame(8'hA3, 1'b1, 1'b1);
    idle(4);
    check("loopback_count", 32'(done_cnt), 32'd3);

    // Start glitch: 4 ticks low must abort at the mid-bit check.
    busy_seen = 1'b0;
    c0 = done_cnt;
    rx = 1'b0;
    wait_ticks(4);
    idle(20);
    check("glitch_busy_pulse", 32'(busy_seen), 32'h1);
    check("glitch_busy_low", 32'(rx_busy), 32'h0);
    check("glitch_no_strobe", 32'(done_cnt), 32'(c0));

    // Bad stop bit, then a good frame clears the flag.
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(20);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(4);

    // Back-to-back frames: strobes exactly one frame (160 ticks) apart.
    send_frame(8'hAA, 1'b1, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(4);
    check("b2b_gap", 32'(gap), 32'd160);

    // Soft clear during data bit 3; bits 3..7 and stop are high so the
    // abandoned frame cannot restart the receiver.
    c0 = done_cnt;
    fork
      send_frame(8'hF8, 1'b1, 1'b0);
      begin
        wait_ticks(BIT_T + BIT_T * 3 + 8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("srst_busy", 32'(rx_busy), 32'h0);
        check("srst_dout", 32'(dout), 32'h0);
        check("srst_ferr", 32'(frame_err), 32'h0);
      end
    join
    idle(4);
    check("srst_no_strobe", 32'(done_cnt), 32'(c0));
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(4);

    // Receiver disabled: frame ignored entirely.
    rx_en = 1'b0;
    busy_seen = 1'b0;
    c0 = done_cnt;
    send_frame(8'h77, 1'b1, 1'b0);
    idle(4);
    check("dis_no_busy", 32'(busy_seen), 32'h0);
    check("dis_no_strobe", 32'(done_cnt), 32'(c0));
    idle(5);
    rx_en = 1'b1;
    idle(5);
    send_frame(8'h77, 1'b1, 1'b1);
    idle(4);

    // Random bytes with occasional stop-bit errors and random gaps.
    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(d, good, 1'b1);
      if (good) idle($urandom_range(0, 6));
      else      idle(8 + $urandom_range(0, 6));
    end
    idle(10);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
